// File: rtl/fix_chk_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | fix_chk_pkg: shared types and constants for fix_stream_checker       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package fix_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_MISMATCH  = 2'd1,
    ERR_UNDERFLOW = 2'd2,
    ERR_TIMEOUT   = 2'd3
  } err_e;

  localparam logic [7:0] SOH = 8'h01;

endpackage
`default_nettype wire

// File: rtl/fix_stream_checker_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | fix_chk_if: stimulus/expected-data and status bundle of the checker |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface fix_chk_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
);
  logic              arm;
  logic              exp_valid;
  logic [DATA_W-1:0] exp_data;
  logic              exp_last;
  logic              exp_ready;
  logic              obs_valid;
  logic [DATA_W-1:0] obs_data;
  logic              busy;
  logic              pass;
  logic              fail;
  logic [1:0]        err_code;
  logic [CNT_W-1:0]  err_index;
  logic [DATA_W-1:0] err_exp;
  logic [DATA_W-1:0] err_got;
  logic [CNT_W-1:0]  byte_count;
  logic [CNT_W-1:0]  msg_count;
  logic [7:0]        msg_sum;
  logic              msg_sum_valid;

  modport master (
    output arm, exp_valid, exp_data, exp_last, obs_valid, obs_data,
    input  exp_ready, busy, pass, fail, err_code, err_index, err_exp, err_got,
           byte_count, msg_count, msg_sum, msg_sum_valid
  );

  modport slave (
    input  arm, exp_valid, exp_data, exp_last, obs_valid, obs_data,
    output exp_ready, busy, pass, fail, err_code, err_index, err_exp, err_got,
           byte_count, msg_count, msg_sum, msg_sum_valid
  );
endinterface
`default_nettype wire

// File: rtl/fix_chk_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | fix_chk_fifo: show-ahead synchronous FIFO with flush                 |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module fix_chk_fifo #(
  parameter int unsigned W     = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush_i,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic         w_wr;
  logic         w_rd;

  assign w_wr    = wr_en_i && !full_o && !flush_i;
  assign w_rd    = rd_en_i && !empty_o && !flush_i;
  // Extra pointer MSB distinguishes full from empty when indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (w_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end
endmodule
`default_nettype wire

// File: rtl/fix_stream_checker.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | fix_stream_checker: in-order byte-stream scoreboard for the FIX engine |
// | Optional per-message checksum: FIX_CHK_CHECKSUM_EN       Rev 1.0     |
// +--------------------------------------------------------------------+
module fix_stream_checker
  import fix_chk_pkg::*;
#(
  parameter int unsigned       DATA_W  = 8,
  parameter int unsigned       DEPTH   = 16,
  parameter logic [DATA_W-1:0] DELIM   = DATA_W'(SOH),
  parameter int unsigned       TIMEOUT = 1024,
  parameter int unsigned       CNT_W   = 16
) (
  input logic      clk,
  input logic      reset_n,
  fix_chk_if.slave bus
);
  localparam int unsigned     WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  state_e            state_q, state_d;
  err_e              err_code_q, err_code_d;
  logic [CNT_W-1:0]  byte_count_q, byte_count_d;
  logic [CNT_W-1:0]  msg_count_q, msg_count_d;
  logic [CNT_W-1:0]  err_index_q, err_index_d;
  logic [DATA_W-1:0] err_exp_q, err_exp_d;
  logic [DATA_W-1:0] err_got_q, err_got_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              w_full, w_empty, w_pop, w_wr;
  logic [DATA_W:0]   w_head;

  assign bus.exp_ready = !w_full && !bus.arm;
  assign w_wr          = bus.exp_valid && bus.exp_ready;

  fix_chk_fifo #(.W(DATA_W + 1), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush_i  (bus.arm),
    .wr_en_i  (w_wr),
    .wr_data_i({bus.exp_last, bus.exp_data}),
    .rd_en_i  (w_pop),
    .full_o   (w_full),
    .empty_o  (w_empty),
    .head_o   (w_head)
  );

  always_comb begin
    state_d      = state_q;
    err_code_d   = err_code_q;
    byte_count_d = byte_count_q;
    msg_count_d  = msg_count_q;
    err_index_d  = err_index_q;
    err_exp_d    = err_exp_q;
    err_got_d    = err_got_q;
    wd_d         = wd_q;
    w_pop        = 1'b0;
    if (bus.arm) begin
      state_d      = ST_RUN;
      err_code_d   = ERR_NONE;
      byte_count_d = '0;
      msg_count_d  = '0;
      err_index_d  = '0;
      err_exp_d    = '0;
      err_got_d    = '0;
      wd_d         = '0;
    end else if (state_q == ST_RUN) begin
      if (bus.obs_valid) begin
        wd_d = '0;
        if (w_empty) begin
          state_d     = ST_FAIL;
          err_code_d  = ERR_UNDERFLOW;
          err_index_d = byte_count_q;
          err_exp_d   = '0;
          err_got_d   = bus.obs_data;
        end else if (w_head[DATA_W-1:0] == bus.obs_data) begin
          w_pop = 1'b1;
          if (byte_count_q != '1) byte_count_d = byte_count_q + CNT_W'(1);
          if (bus.obs_data == DELIM && msg_count_q != '1)
            msg_count_d = msg_count_q + CNT_W'(1);
          if (w_head[DATA_W]) state_d = ST_PASS;
        end else begin
          state_d     = ST_FAIL;
          err_code_d  = ERR_MISMATCH;
          err_index_d = byte_count_q;
          err_exp_d   = w_head[DATA_W-1:0];
          err_got_d   = bus.obs_data;
        end
      end else if (TIMEOUT > 0) begin
        if (wd_q == WD_LAST) begin
          state_d     = ST_FAIL;
          err_code_d  = ERR_TIMEOUT;
          err_index_d = byte_count_q;
          err_exp_d   = '0;
          err_got_d   = '0;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      err_code_q   <= ERR_NONE;
      byte_count_q <= '0;
      msg_count_q  <= '0;
      err_index_q  <= '0;
      err_exp_q    <= '0;
      err_got_q    <= '0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      err_code_q   <= err_code_d;
      byte_count_q <= byte_count_d;
      msg_count_q  <= msg_count_d;
      err_index_q  <= err_index_d;
      err_exp_q    <= err_exp_d;
      err_got_q    <= err_got_d;
      wd_q         <= wd_d;
    end
  end

  assign bus.busy       = (state_q == ST_RUN);
  assign bus.pass       = (state_q == ST_PASS);
  assign bus.fail       = (state_q == ST_FAIL);
  assign bus.err_code   = err_code_q;
  assign bus.err_index  = err_index_q;
  assign bus.err_exp    = err_exp_q;
  assign bus.err_got    = err_got_q;
  assign bus.byte_count = byte_count_q;
  assign bus.msg_count  = msg_count_q;

`ifdef FIX_CHK_CHECKSUM_EN
  logic [7:0] sum_q, sum_d, msum_q, msum_d, w_sum_next;
  logic       msum_valid_q, msum_valid_d, w_match;

  assign w_match    = (state_q == ST_RUN) && bus.obs_valid && !bus.arm && !w_empty &&
                      (w_head[DATA_W-1:0] == bus.obs_data);
  assign w_sum_next = sum_q + 8'(bus.obs_data);

  // The delimiter is part of its own message's sum; the next message starts at 0.
  always_comb begin
    sum_d        = sum_q;
    msum_d       = msum_q;
    msum_valid_d = 1'b0;
    if (bus.arm) begin
      sum_d  = '0;
      msum_d = '0;
    end else if (w_match) begin
      if (bus.obs_data == DELIM) begin
        msum_d       = w_sum_next;
        msum_valid_d = 1'b1;
        sum_d        = '0;
      end else begin
        sum_d = w_sum_next;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q        <= '0;
      msum_q       <= '0;
      msum_valid_q <= 1'b0;
    end else begin
      sum_q        <= sum_d;
      msum_q       <= msum_d;
      msum_valid_q <= msum_valid_d;
    end
  end

  assign bus.msg_sum       = msum_q;
  assign bus.msg_sum_valid = msum_valid_q;
`else
  assign bus.msg_sum       = '0;
  assign bus.msg_sum_valid = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_fix_stream_checker.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fix_stream_checker: scoreboard bench for fix_stream_checker        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_fix_stream_checker;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

`ifdef FIX_CHK_CHECKSUM_EN
  localparam int EXP_PULSES = 1;
  localparam int EXP_SUM    = 32'h31;
`else
  localparam int EXP_PULSES = 0;
  localparam int EXP_SUM    = 0;
`endif

  fix_chk_if #(.DATA_W(8), .CNT_W(16)) i0 ();
  fix_chk_if #(.DATA_W(8), .CNT_W(16)) i1 ();

  fix_stream_checker #(.DATA_W(8), .DEPTH(16), .DELIM(8'h01), .TIMEOUT(8), .CNT_W(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(i0)
  );
  fix_stream_checker #(.DATA_W(8), .DEPTH(16), .DELIM(8'h01), .TIMEOUT(0), .CNT_W(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(i1)
  );

  // sel steers the shared stimulus to one checker; the other sees idle inputs.
  logic       sel = 1'b0, arm_r = 1'b0, ev_r = 1'b0, el_r = 1'b0, ov_r = 1'b0;
  logic [7:0] ed_r = 8'h00, od_r = 8'h00;
  assign i0.arm       = arm_r & ~sel;
  assign i1.arm       = arm_r & sel;
  assign i0.exp_valid = ev_r & ~sel;
  assign i1.exp_valid = ev_r & sel;
  assign i0.obs_valid = ov_r & ~sel;
  assign i1.obs_valid = ov_r & sel;
  assign i0.exp_data  = ed_r;
  assign i1.exp_data  = ed_r;
  assign i0.exp_last  = el_r;
  assign i1.exp_last  = el_r;
  assign i0.obs_data  = od_r;
  assign i1.obs_data  = od_r;

  typedef struct {
    logic        pass;
    logic [1:0]  code;
    logic [15:0] idx;
    logic [7:0]  eexp;
    logic [7:0]  egot;
    logic [15:0] bc;
    logic [15:0] mc;
  } verdict_t;

  verdict_t   exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         sum_pulses = 0;
  logic [7:0] sum_last = 8'h00;
  logic       prev_term = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic expect_v(input logic p, input logic [1:0] c, input logic [15:0] idx,
                          input logic [7:0] ee, input logic [7:0] eg,
                          input logic [15:0] bc, input logic [15:0] mc);
    verdict_t v;
    v.pass = p; v.code = c; v.idx = idx; v.eexp = ee; v.egot = eg; v.bc = bc; v.mc = mc;
    exp_q.push_back(v);
  endtask

  // Monitor: each new PASS/FAIL verdict of checker 0 is compared against the queue head.
  always @(negedge clk) begin
    verdict_t v;
    if (i0.msg_sum_valid) begin
      sum_pulses++;
      sum_last = i0.msg_sum;
    end
    if ((i0.pass || i0.fail) && !prev_term) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_verdict: got pass=%0b fail=%0b want none", i0.pass, i0.fail);
      end else begin
        v = exp_q.pop_front();
        check("v_pass",       32'(i0.pass),       32'(v.pass));
        check("v_fail",       32'(i0.fail),       32'(!v.pass));
        check("v_err_code",   32'(i0.err_code),   32'(v.code));
        check("v_err_index",  32'(i0.err_index),  32'(v.idx));
        check("v_err_exp",    32'(i0.err_exp),    32'(v.eexp));
        check("v_err_got",    32'(i0.err_got),    32'(v.egot));
        check("v_byte_count", 32'(i0.byte_count), 32'(v.bc));
        check("v_msg_count",  32'(i0.msg_count),  32'(v.mc));
      end
    end
    prev_term = i0.pass || i0.fail;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm_r = 1'b1;
    tick();
    arm_r = 1'b0;
  endtask

  task automatic load(input logic [7:0] d, input logic l);
    ev_r = 1'b1; ed_r = d; el_r = l;
    tick();
    ev_r = 1'b0; el_r = 1'b0;
  endtask

  task automatic obs(input logic [7:0] d);
    ov_r = 1'b1; od_r = d;
    tick();
    ov_r = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    repeat (3) tick();
    check("rst_busy",       32'(i0.busy),          32'd0);
    check("rst_pass",       32'(i0.pass),          32'd0);
    check("rst_fail",       32'(i0.fail),          32'd0);
    check("rst_err_code",   32'(i0.err_code),      32'd0);
    check("rst_byte_count", 32'(i0.byte_count),    32'd0);
    check("rst_msg_sum",    32'(i0.msg_sum_valid), 32'd0);
    check("rst_exp_ready",  32'(i0.exp_ready),     32'd1);
    reset_n = 1'b1;
    tick();

    // Two SOH-terminated messages, all bytes match.
    do_arm();
    check("arm_busy", 32'(i0.busy), 32'd1);
    load(8'h41, 1'b0); load(8'h01, 1'b0); load(8'h42, 1'b0); load(8'h01, 1'b1);
    expect_v(1'b1, 2'd0, 16'd0, 8'h00, 8'h00, 16'd4, 16'd2);
    obs(8'h41); obs(8'h01); obs(8'h42); obs(8'h01);

    // Mismatch on the second byte; later traffic must not disturb the capture.
    do_arm();
    load(8'h41, 1'b0); load(8'h42, 1'b0); load(8'h43, 1'b1);
    expect_v(1'b0, 2'd1, 16'd1, 8'h42, 8'h58, 16'd1, 16'd0);
    obs(8'h41); obs(8'h58); obs(8'h43);
    check("sticky_fail",     32'(i0.fail),       32'd1);
    check("sticky_err_got",  32'(i0.err_got),    32'h58);
    check("sticky_err_code", 32'(i0.err_code),   32'd1);
    check("sticky_bytes",    32'(i0.byte_count), 32'd1);

    // Compare against an empty FIFO while the first byte is being written.
    do_arm();
    expect_v(1'b0, 2'd2, 16'd0, 8'h00, 8'h41, 16'd0, 16'd0);
    ev_r = 1'b1; ed_r = 8'h41; el_r = 1'b1; ov_r = 1'b1; od_r = 8'h41;
    tick();
    ev_r = 1'b0; el_r = 1'b0; ov_r = 1'b0;

    // Watchdog: 8 RUN cycles with no observed byte.
    do_arm();
    expect_v(1'b0, 2'd3, 16'd0, 8'h00, 8'h00, 16'd0, 16'd0);
    n = 0;
    load(8'h41, 1'b0); n++;
    load(8'h42, 1'b1); n++;
    while (!i0.fail && n < 40) begin
      tick();
      n++;
    end
    check("timeout_cycles", 32'(n), 32'd8);

    // Per-message checksum over 10 20 01.
    do_arm();
    sum_pulses = 0;
    sum_last = 8'h00;
    load(8'h10, 1'b0); load(8'h20, 1'b0); load(8'h01, 1'b1);
    expect_v(1'b1, 2'd0, 16'd0, 8'h00, 8'h00, 16'd3, 16'd1);
    obs(8'h10); obs(8'h20); obs(8'h01);
    tick();
    check("sum_pulses",    32'(sum_pulses),       32'(EXP_PULSES));
    check("sum_value",     32'(sum_last),         32'(EXP_SUM));
    check("sum_one_cycle", 32'(i0.msg_sum_valid), 32'd0);

    // Checker 1 (watchdog disabled): fill to full, idle, then pop one entry.
    sel = 1'b1;
    do_arm();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("ready_before_full", 32'(i1.exp_ready), 32'd1);
      load(8'(i), (i == 15));
    end
    check("ready_when_full", 32'(i1.exp_ready), 32'd0);
    ev_r = 1'b1; ed_r = 8'hAA;
    tick();
    ev_r = 1'b0;
    check("ready_still_full", 32'(i1.exp_ready), 32'd0);
    repeat (20) tick();
    check("nowd_busy", 32'(i1.busy), 32'd1);
    check("nowd_fail", 32'(i1.fail), 32'd0);
    obs(8'h00);
    check("pop_ready", 32'(i1.exp_ready),  32'd1);
    check("pop_bytes", 32'(i1.byte_count), 32'd1);

    // Asynchronous reset in the middle of a cycle.
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy",       32'(i1.busy),       32'd0);
    check("arst_bytes",      32'(i1.byte_count), 32'd0);
    check("arst_exp_ready",  32'(i1.exp_ready),  32'd1);
    check("arst_pass0",      32'(i0.pass),       32'd0);
    check("arst_err_code0",  32'(i0.err_code),   32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("arst_empty_fifo", 32'(i1.exp_ready), 32'd1);
    check("verdicts_seen",   32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fix_stream_checker.md
# fix_stream_checker

Synthesizable, parametrised byte-stream checker for the FIX engine. Expected bytes are loaded into an internal FIFO and compared in order against the engine's output stream (`dout`/`valid`). The checker reports pass/fail with first-error capture, byte and message counters and an inactivity watchdog. It sits beside the engine in the bench and in on-board self-test builds, replacing file-based comparison with a hardware scoreboard.

## Interface
Parameters:
- DATA_W, 8, stream byte width
- DEPTH, 16, expected-FIFO entries (power of two, ≥2)
- DELIM, 8'h01, message-delimiter value (SOH)
- TIMEOUT, 1024, idle cycles in RUN before timeout fail; 0 disables the watchdog
- CNT_W, 16, width of the counters and err_index

Ports:
- clk  in  1  rising-edge clock; the block has one clock
- reset_n  in  1  asynchronous, active-low reset
- arm  in  1  single-cycle pulse; flushes FIFO, clears status, enters RUN
- exp_valid  in  1  expected byte offered
- exp_data  in  DATA_W  expected byte
- exp_last  in  1  marks final expected byte of the test
- exp_ready  out  1  FIFO can accept; = !full && !arm
- obs_valid  in  1  engine output byte valid
- obs_data  in  DATA_W  engine output byte
- busy / pass / fail  out  1 each  state is RUN / PASS / FAIL
- err_code  out  2  0 none, 1 mismatch, 2 underflow, 3 timeout
- err_index  out  CNT_W  byte index (0-based) of first error
- err_exp / err_got  out  DATA_W  expected/observed byte at first error
- byte_count / msg_count  out  CNT_W  matched bytes / matched DELIM bytes, saturating
- msg_sum  out  8  per-message byte sum mod 256
- msg_sum_valid  out  1  one-cycle strobe with msg_sum

## Operation
- States are IDLE, RUN, PASS and FAIL. Reset enters IDLE. arm from any state enters RUN.
- On the arm cycle:
  - FIFO is flushed.
  - Counters, err_*, watchdog and sum are zeroed.
  - obs_valid and exp_valid are ignored.
- Loading: exp_valid && exp_ready writes {exp_last, exp_data}. Loading is allowed in every state.
- Comparison happens in RUN on obs_valid:
  - FIFO non-empty, head == obs_data: pop. Increment byte_count. Increment msg_count if byte == DELIM. If head.last is set, go to PASS.
  - FIFO non-empty, mismatch: go to FAIL with err_code 1. Capture byte_count as err_index, plus head and obs_data. Pop nothing.
  - FIFO empty: go to FAIL with err_code 2, err_exp = 0.
- A write into an empty FIFO is not visible to a same-cycle compare. Such a compare is an underflow.
- Watchdog (TIMEOUT > 0): counts RUN cycles without obs_valid and clears on obs_valid. Reaching TIMEOUT goes to FAIL with err_code 3, err_index = byte_count.
- obs_valid in IDLE, PASS or FAIL is ignored. Counters freeze.
- FAIL is sticky until arm or reset. Only the first error is recorded.
- Counters saturate at all-ones.

## Timing
- All outputs are registered. Reset value of every output is 0, except exp_ready, which is 1.
- A compare at edge N is reflected in pass, fail, err_* and counters after edge N. They are visible in cycle N+1.
- Full FIFO drops exp_ready in the same cycle it becomes full. There is no write-through when full, even with a simultaneous pop.
- Latency from exp write to compare-eligible is 1 cycle.
- Asynchronous reset mid-run returns to IDLE immediately and discards FIFO contents.

## Configuration
- FIX_CHK_CHECKSUM_EN defined:
  - An 8-bit accumulator sums every matched byte, including the DELIM byte.
  - On a DELIM match, msg_sum takes the final sum and msg_sum_valid pulses for one cycle (cycle N+1).
  - The accumulator then restarts at 0. arm also clears it.
- Undefined: msg_sum and msg_sum_valid are tied to 0 and no accumulator is built.

## Structure
- Package fix_chk_pkg holds:
  - the state enum (IDLE, RUN, PASS, FAIL)
  - the err_code enum
  - the default DELIM constant SOH = 8'h01
- Sub-module fix_chk_fifo: synchronous FIFO, DEPTH × (DATA_W+1), with flush, full, empty and head output (show-ahead).
- Top-level contents: FSM, compare, counters, watchdog, checksum.

## Test plan
- Load 41 01 42 01(last), arm, observe same → after last compare: pass=1, byte_count=4, msg_count=2, err_code=0.
- Load 41 42 43(last), observe 41 58 → fail=1, err_code=1, err_index=1, err_exp=42, err_got=58; a later 43 is ignored.
- Arm with empty FIFO, obs_valid 41 with simultaneous exp write → fail, err_code=2, err_index=0.
- TIMEOUT=8, load 2 bytes, arm, no obs → fail after 8 RUN cycles, err_code=3; repeat with TIMEOUT=0 → stays busy.
- Fill 16 entries → exp_ready=0 while full; pop one → exp_ready=1 next cycle. reset_n low mid-run → all outputs 0, exp_ready=1, IDLE.
- FIX_CHK_CHECKSUM_EN: observe 10 20 01 → msg_sum=8'h31 with one-cycle msg_sum_valid; without the macro both stay 0.
